rgb_stream_to_rgba_framer: RTL and testbench
============================================

Name: rgb_stream_to_rgba_framer

Overview:
- Sits between the video-in scaler's Avalon-ST source (24-bit RGB, packetised by startofpacket/endofpacket) and the RGBA image sink of the image-processing path (32-bit data plus a data_valid strobe, with image width and height).
- Appends an alpha byte to each pixel and tracks raster position.
- Validates frame geometry against the configured dimensions.
- Drops malformed or gated frames so the downstream sink only sees whole, frame-aligned images.

Parameters:
IMG_W  320  expected pixels per line (>=2)
IMG_H  240  expected lines per frame (>=1)
ALPHA  8'hFF  alpha byte appended to every pixel
DIM_W  16  width of dimension/position outputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
sink_data  in  24  RGB pixel, {R[23:16],G[15:8],B[7:0]}
sink_startofpacket  in  1  first pixel of frame
sink_endofpacket  in  1  last pixel of frame
sink_valid  in  1  beat valid
sink_ready  out  1  beat accepted when sink_valid&sink_ready (ready latency 0)
enable  in  1  frame gate; sampled only at a candidate SOP
err_clear  in  1  clears err_flag and err_count
out_data  out  32  {R,G,B,ALPHA}
out_valid  out  1  one-cycle strobe per emitted pixel
out_img_width  out  DIM_W  constant IMG_W
out_img_height  out  DIM_W  constant IMG_H
frame_start  out  1  pulse coincident with the first emitted pixel of a frame
frame_done  out  1  pulse coincident with the last pixel of a good frame
pix_x  out  DIM_W  column of the pixel on out_data
pix_y  out  DIM_W  line of the pixel on out_data
err_flag  out  1  sticky geometry error
err_count  out  8  saturating count of bad frames
frame_count  out  16  count of good frames, wraps at 65535->0

Behaviour:
- Reset (sync, 1 cycle):
  - State is SEEK; x and y are 0.
  - sink_ready=0 during reset; sink_ready=1 from the first cycle after reset and stays at 1 (no backpressure).
  - out_valid, frame_start, frame_done and err_flag are 0. out_data, pix_x and pix_y are 0. err_count and frame_count are 0.
- Reset mid-frame abandons the frame silently: no error is raised and no pulse is generated.
- Latency: all outputs are registered. A beat accepted in cycle N appears at cycle N+1.
- Beat = sink_valid&sink_ready. No output pulses are generated in cycles without a beat.
- SEEK:
  - Beat with sop=0 -> discarded.
  - Beat with sop=1 and enable=0 -> discarded; stay in SEEK.
  - Beat with sop=1 and enable=1 -> emit the pixel with pix_x=0, pix_y=0 and frame_start=1; go to ACTIVE with x=1, y=0.
  - If that SOP beat also has eop=1 -> short-frame error; stay in SEEK.
- ACTIVE, each beat (position is the current x,y):
  - sop=1 -> error on the current frame. That beat is treated as a fresh SOP: enable is checked, and if enable=1 the pixel is emitted with frame_start=1 and x,y restart. If enable=0 -> go to SEEK.
  - Otherwise the pixel is emitted at (x,y).
  - x advances: if x==IMG_W-1 then x=0 and y=y+1, else x=x+1.
  - Last position (x==IMG_W-1, y==IMG_H-1) with eop=1 -> frame_done=1, frame_count+1; go to SEEK.
  - Last position with eop=0 -> long-frame error; go to SEEK. Further beats are discarded until the next SOP.
  - eop=1 before the last position -> short-frame error; go to SEEK. The pixel is still emitted.
- Error event:
  - err_flag<=1.
  - err_count increments and saturates at 255.
  - frame_done is not pulsed for the bad frame.
- err_clear:
  - Clears err_flag and err_count next cycle.
  - If err_clear coincides with an error event, the error wins: err_flag=1 and err_count=1.
- enable deasserted mid-frame has no effect; the current frame completes.
- Counter widths:
  - x and y are DIM_W bits.
  - Comparisons use IMG_W-1 and IMG_H-1 truncated to DIM_W.
  - No wrap is possible because the position resets at the frame boundary.
- out_img_width and out_img_height are constant from reset.

Test Plan:
1. IMG_W=4, IMG_H=2, enable=1, send 8 beats (sop on beat 0, eop on beat 7), data 0x112233 first -> out_data=0x112233FF. Expect 8 out_valid pulses with pix (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), frame_start on the 1st, frame_done on the 8th, frame_count=1, err_flag=0.
2. Same frame with eop on beat 5 -> 6 pixels emitted, no frame_done, err_flag=1, err_count=1. A following good frame -> frame_done, frame_count increments.
3. 10 beats with no eop by beat 7 -> 8 pixels emitted, beats 8-9 dropped, err_count+1. The next SOP frame is accepted normally.
4. enable=0 at SOP, 8-beat frame -> zero out_valid. Raise enable mid-frame -> still none. Next SOP -> full frame emitted.
5. Second SOP at beat 3 of an active frame -> err_count+1, frame_start at that beat, pix=(0,0), subsequent 8-beat frame completes with frame_done.
6. Reset asserted at beat 4 of a frame -> all outputs 0 next cycle, no error. err_clear asserted with concurrent error -> err_count=1, err_flag=1. 300 bad frames -> err_count=255.

Source files
------------

// File: rtl/rgb_stream_to_rgba_framer.sv
// rgb_stream_to_rgba_framer
// Turns a packetised 24-bit RGB stream into frame-aligned 32-bit RGBA pixels
// with raster position. Frames whose geometry disagrees with IMG_W x IMG_H,
// or that are gated off by enable at their SOP, never reach the sink as
// complete images. Bad frames are counted in err_count and raise err_flag.
//
// Handshake: a beat is transferred when sink_valid & sink_ready in the same
// cycle (ready latency 0). sink_ready is low only while reset is high, so the
// block never back-pressures the source. out_valid is a one-cycle strobe with
// no ready; every output is registered one cycle behind the beat it reports.
module rgb_stream_to_rgba_framer #(
  parameter int           IMG_W = 320,
  parameter int           IMG_H = 240,
  parameter logic [7:0]   ALPHA = 8'hFF,
  parameter int           DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      sink_data,
  input  logic             sink_startofpacket,
  input  logic             sink_endofpacket,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic             enable,
  input  logic             err_clear,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic [DIM_W-1:0] out_img_width,
  output logic [DIM_W-1:0] out_img_height,
  output logic             frame_start,
  output logic             frame_done,
  output logic [DIM_W-1:0] pix_x,
  output logic [DIM_W-1:0] pix_y,
  output logic             err_flag,
  output logic [7:0]       err_count,
  output logic [15:0]      frame_count,
  output logic             dbg_state
);

  typedef enum logic {
    SEEK   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [DIM_W-1:0] X_LAST = DIM_W'(IMG_W - 1);
  localparam logic [DIM_W-1:0] Y_LAST = DIM_W'(IMG_H - 1);

  state_t           state_q, state_d;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;
  logic [DIM_W-1:0] px_q, px_d;
  logic [DIM_W-1:0] py_q, py_d;
  logic             eflag_q, eflag_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             beat;
  logic             err_ev;

  assign sink_ready     = ~reset;
  assign beat           = sink_valid & sink_ready;
  assign out_img_width  = DIM_W'(IMG_W);
  assign out_img_height = DIM_W'(IMG_H);
  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign frame_start    = fs_q;
  assign frame_done     = fd_q;
  assign pix_x          = px_q;
  assign pix_y          = py_q;
  assign err_flag       = eflag_q;
  assign err_count      = ecnt_q;
  assign frame_count    = fcnt_q;
  assign dbg_state      = state_q;

  // Next-state: frame tracking, pixel emission and error detection per beat
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    px_d    = px_q;
    py_d    = py_q;
    err_ev  = 1'b0;
    if (beat) begin
      if (sink_startofpacket) begin
        // An SOP inside an active frame kills that frame, then restarts.
        if (state_q == ACTIVE) err_ev = 1'b1;
        state_d = SEEK;
        x_d     = '0;
        y_d     = '0;
        if (enable) begin
          valid_d = 1'b1;
          fs_d    = 1'b1;
          data_d  = {sink_data, ALPHA};
          px_d    = '0;
          py_d    = '0;
          if (sink_endofpacket) begin
            err_ev = 1'b1;
          end else begin
            state_d = ACTIVE;
            x_d     = DIM_W'(1);
          end
        end
      end else if (state_q == ACTIVE) begin
        valid_d = 1'b1;
        data_d  = {sink_data, ALPHA};
        px_d    = x_q;
        py_d    = y_q;
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = SEEK;
          x_d     = '0;
          y_d     = '0;
          if (sink_endofpacket) fd_d = 1'b1;
          else                  err_ev = 1'b1;
        end else if (sink_endofpacket) begin
          state_d = SEEK;
          x_d     = '0;
          y_d     = '0;
          err_ev  = 1'b1;
        end else if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + DIM_W'(1);
        end else begin
          x_d = x_q + DIM_W'(1);
        end
      end
    end
  end

  // Next-state: sticky error flag, saturating error count, good-frame count
  always_comb begin
    eflag_d = eflag_q;
    ecnt_d  = ecnt_q;
    fcnt_d  = fcnt_q + {15'd0, fd_d};
    if (err_ev) begin
      eflag_d = 1'b1;
      if (err_clear)             ecnt_d = 8'd1;
      else if (ecnt_q != 8'hFF)  ecnt_d = ecnt_q + 8'd1;
    end else if (err_clear) begin
      eflag_d = 1'b0;
      ecnt_d  = 8'd0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEEK;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      eflag_q <= 1'b0;
      ecnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      px_q    <= px_d;
      py_q    <= py_d;
      eflag_q <= eflag_d;
      ecnt_q  <= ecnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_rgb_stream_to_rgba_framer.sv
// Bench for rgb_stream_to_rgba_framer with a 4x2 image. A frame-level model
// (linear pixel index, in-frame flag) predicts every cycle's outputs into
// exp_q; observed outputs go to got_q; each test drains and compares both.
module tb_rgb_stream_to_rgba_framer;

  localparam int         IMG_W = 4;
  localparam int         IMG_H = 2;
  localparam int         NPIX  = IMG_W * IMG_H;
  localparam logic [7:0] ALPHA = 8'hFF;

  typedef struct packed {
    logic        v;
    logic        fs;
    logic        fd;
    logic [31:0] d;
    logic [15:0] px;
    logic [15:0] py;
    logic        ef;
    logic [7:0]  ec;
    logic [15:0] fc;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // clock / reset / DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] sink_data = '0;
  logic        sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
  logic        sink_ready;
  logic        enable = 1'b0, err_clear = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, frame_start, frame_done, err_flag, dbg_state;
  logic [15:0] out_img_width, out_img_height, pix_x, pix_y, frame_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  rgb_stream_to_rgba_framer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ALPHA(ALPHA), .DIM_W(16)) dut (
    .clk(clk), .reset(reset), .sink_data(sink_data),
    .sink_startofpacket(sink_sop), .sink_endofpacket(sink_eop),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .enable(enable), .err_clear(err_clear),
    .out_data(out_data), .out_valid(out_valid),
    .out_img_width(out_img_width), .out_img_height(out_img_height),
    .frame_start(frame_start), .frame_done(frame_done),
    .pix_x(pix_x), .pix_y(pix_y), .err_flag(err_flag),
    .err_count(err_count), .frame_count(frame_count), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] got_q[$];

  // reference model state
  bit          m_in;
  int          m_pos;
  bit          m_ef;
  int          m_ec;
  logic [15:0] m_fc;
  logic [31:0] m_d;
  logic [15:0] m_px, m_py;

  function automatic obs_t model(input logic [23:0] d, input logic sop, eop, v, en, clr, rst);
    obs_t o = '0;
    bit err = 0;
    if (rst) begin
      m_in = 0; m_pos = 0; m_ef = 0; m_ec = 0; m_fc = '0;
      m_d = '0; m_px = '0; m_py = '0;
      return o;
    end
    if (v) begin
      if (sop) begin
        if (m_in) err = 1;
        m_in = 0;
        if (en) begin
          o.v = 1; o.fs = 1;
          m_d = {d, ALPHA}; m_px = 0; m_py = 0;
          if (eop) err = 1;
          else begin m_in = 1; m_pos = 1; end
        end
      end else if (m_in) begin
        o.v = 1;
        m_d = {d, ALPHA};
        m_px = 16'(m_pos % IMG_W);
        m_py = 16'(m_pos / IMG_W);
        if (m_pos == NPIX - 1) begin
          m_in = 0;
          if (eop) begin o.fd = 1; m_fc = m_fc + 16'd1; end
          else err = 1;
        end else if (eop) begin
          err = 1; m_in = 0;
        end else begin
          m_pos++;
        end
      end
    end
    if (err) begin
      m_ef = 1;
      m_ec = clr ? 1 : (m_ec == 255 ? 255 : m_ec + 1);
    end else if (clr) begin
      m_ef = 0; m_ec = 0;
    end
    o.d = m_d; o.px = m_px; o.py = m_py;
    o.ef = m_ef; o.ec = 8'(m_ec); o.fc = m_fc;
    return o;
  endfunction

  // driver: apply one cycle of inputs, sample outputs #1 after the edge
  task automatic step(input logic [23:0] d, input logic sop, eop, v, en, clr, rst);
    obs_t g;
    sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = v;
    enable = en; err_clear = clr; reset = rst;
    @(posedge clk); #1;
    exp_q.push_back(model(d, sop, eop, v, en, clr, rst));
    g = '{out_valid, frame_start, frame_done, out_data, pix_x, pix_y,
          err_flag, err_count, frame_count};
    got_q.push_back(g);
  endtask

  // one frame of nbeats; eop at eop_at, extra sop at sop2_at, enable from en_at
  task automatic send_frame(input int nbeats, eop_at, sop2_at, input logic en, input int en_at);
    logic [23:0] d;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(24'($urandom), 1'($urandom), 1'($urandom), 1'b0, en, 1'b0, 1'b0);
      d = (i == 0) ? 24'h112233 : 24'($urandom);
      step(d, (i == 0) || (i == sop2_at), i == eop_at, 1'b1,
           (en_at >= 0 && i >= en_at) ? 1'b1 : en, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    step('0, 0, 0, 1, 1, 0, 1);
    checks++;
    if (sink_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, expected 0", sink_ready); end
    step('0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({out_valid, frame_start, frame_done, err_flag, out_data, pix_x, pix_y, err_count, frame_count} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b%b%b%b %h %h %h %h %h, expected all zero",
                         out_valid, frame_start, frame_done, err_flag, out_data, pix_x, pix_y, err_count, frame_count);
    end
    step('0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sink_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b, expected 1", sink_ready); end
    checks++;
    if (out_img_width !== 16'd4 || out_img_height !== 16'd2) begin
      errors++; $display("FAIL dims: got %0d x %0d, expected 4 x 2", out_img_width, out_img_height);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_good_frame();
    obs_t e, g; int nv = 0, nfs = 0, nfd = 0;
    send_frame(8, 7, -1, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nv += int'(g.v); nfs += int'(g.fs); nfd += int'(g.fd);
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL good_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nv != 8 || nfs != 1 || nfd != 1) begin errors++; $display("FAIL good_counts: got v=%0d fs=%0d fd=%0d, expected 8 1 1", nv, nfs, nfd); end
    checks++;
    if (frame_count !== 16'd1 || err_flag !== 1'b0) begin errors++; $display("FAIL good_status: got fc=%0d ef=%b, expected 1 0", frame_count, err_flag); end
  endtask

  task automatic test_short_frame();
    obs_t e, g; int nv = 0;
    send_frame(6, 5, -1, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nv += int'(g.v);
      if (g.fd) begin errors++; $display("FAIL short_done: got frame_done 1, expected 0"); end
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL short_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nv != 6 || err_flag !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL short_status: got v=%0d ef=%b ec=%0d, expected 6 1 1", nv, err_flag, err_count);
    end
    send_frame(8, 7, -1, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL short_next_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL short_next_fc: got %0d, expected 2", frame_count); end
  endtask

  task automatic test_long_frame();
    obs_t e, g; int nv = 0;
    send_frame(10, -1, -1, 1'b1, -1);
    send_frame(8, 7, -1, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nv += int'(g.v);
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL long_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nv != 16 || err_count !== 8'd2 || frame_count !== 16'd3) begin
      errors++; $display("FAIL long_status: got v=%0d ec=%0d fc=%0d, expected 16 2 3", nv, err_count, frame_count);
    end
  endtask

  task automatic test_enable_gate();
    obs_t e, g; int nv = 0;
    send_frame(8, 7, -1, 1'b0, 4);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nv += int'(g.v);
      checks++;
      if (g.v !== e.v || g.ec !== e.ec || g.fc !== e.fc) begin errors++; $display("FAIL gate_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL gate_count: got %0d pixels, expected 0", nv); end
    send_frame(8, 7, -1, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nv += int'(g.v);
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL gate_next_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nv != 8 || frame_count !== 16'd4) begin errors++; $display("FAIL gate_next: got v=%0d fc=%0d, expected 8 4", nv, frame_count); end
  endtask

  task automatic test_resync_sop();
    obs_t e, g; int nfs = 0, nfd = 0;
    send_frame(11, 10, 3, 1'b1, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      nfs += int'(g.fs); nfd += int'(g.fd);
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL resync_beat: got %h, expected %h", g, e); end
    end
    checks++;
    if (nfs != 2 || nfd != 1 || err_count !== 8'd3 || frame_count !== 16'd5) begin
      errors++; $display("FAIL resync_status: got fs=%0d fd=%0d ec=%0d fc=%0d, expected 2 1 3 5", nfs, nfd, err_count, frame_count);
    end
  endtask

  task automatic test_reset_and_clear();
    obs_t e, g;
    send_frame(4, -1, -1, 1'b1, -1);
    step(24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({out_valid, frame_start, frame_done, err_flag, out_data, pix_x, pix_y, err_count, frame_count} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got v=%b ef=%b d=%h ec=%0d fc=%0d, expected all zero",
                         out_valid, err_flag, out_data, err_count, frame_count);
    end
    exp_q.delete(); got_q.delete();
    // non-SOP beats after reset must be dropped without error
    for (int i = 0; i < 4; i++) step(24'($urandom), 1'b0, i == 3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(24'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(24'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd1 || err_flag !== 1'b1) begin errors++; $display("FAIL clear_vs_error: got ec=%0d ef=%b, expected 1 1", err_count, err_flag); end
    step(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd0 || err_flag !== 1'b0) begin errors++; $display("FAIL clear: got ec=%0d ef=%b, expected 0 0", err_count, err_flag); end
    for (int i = 0; i < 300; i++) step(24'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 8'd255 || err_flag !== 1'b1) begin errors++; $display("FAIL saturate: got ec=%0d ef=%b, expected 255 1", err_count, err_flag); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL clear_beat: got %h, expected %h", g, e); end
    end
  endtask

  task automatic test_random();
    obs_t e, g;
    int n;
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(1, 12);
      send_frame(n, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n - 1,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, 11) : -1,
                 $urandom_range(0, 5) != 0, -1);
      if ($urandom_range(0, 9) == 0) step(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (!e.v) begin e.d = '0; e.px = '0; e.py = '0; g.d = '0; g.px = '0; g.py = '0; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL random_beat: got %h, expected %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_enable_gate();
    test_resync_sop();
    test_reset_and_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
